// File: rtl/quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// quad_encoder_gen
// Quadrature signal generator. This is the transmit-side partner of the tach
// counter. It accepts step commands (a direction and an edge count) and emits a
// 2-bit Gray-code A/B pair at a programmable edge rate. It also keeps a 16-bit
// position that wraps modulo 2^16.
//
// Optional feature: define QENC_INDEX_EN to add the angle counter (0..CPR-1)
// and a registered once-per-revolution index output. Without the macro the
// angle logic is absent and index is tied to 0.
//
// Ports
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         asynchronous reset, active low
//   period     in   PERIOD_W  clocks between edges; sampled on command accept
//   invphase   in   1         swaps tach[0] and tach[1] at the output
//   cmd_valid  in   1         a command is presented
//   cmd_ready  out  1         generator is idle and can take a command
//   cmd_dir    in   1         1 = up (position increments), 0 = down
//   cmd_steps  in   16        number of quadrature edges to emit
//   abort      in   1         stops the running command with no done pulse
//   tach       out  2         Gray-code quadrature pair
//   counth     out  8         position[15:8]
//   countl     out  8         position[7:0]
//   busy       out  1         a command is running
//   done       out  1         one-cycle pulse when a command completes
//   index      out  1         revolution marker (QENC_INDEX_EN only, else 0)
// -----------------------------------------------------------------------------
module quad_encoder_gen #(
  parameter int CPR      = 400,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                invphase,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [15:0]         cmd_steps,
  input  logic                abort,
  output logic [1:0]          tach,
  output logic [7:0]          counth,
  output logic [7:0]          countl,
  output logic                busy,
  output logic                done,
  output logic                index
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PER_ZERO = {PERIOD_W{1'b0}};

  // Map a 2-bit phase count onto the Gray sequence 00,01,11,10.
  function automatic logic [1:0] bin2gray(input logic [1:0] b);
    return b ^ {1'b0, b[1]};
  endfunction

  state_t              state_r;
  logic                dir_r;
  logic [PERIOD_W-1:0] per_r;
  logic [PERIOD_W-1:0] div_r;
  logic [15:0]         remaining_r;
  logic [1:0]          phase_r;
  logic [1:0]          tach_r;
  logic [15:0]         pos_r;
  logic                done_r;

  logic [PERIOD_W-1:0] per_s;
  logic [1:0]          phase_step_s;
  logic [15:0]         pos_step_s;
  logic                fire_s;

  // Period clamp, edge strobe and the next phase/position for the latched direction.
  always_comb begin
    per_s        = period;
    phase_step_s = phase_r;
    pos_step_s   = pos_r;
    fire_s       = 1'b0;
    if (period == PER_ZERO) begin
      per_s = PER_ONE;
    end else begin
      per_s = period;
    end
    if (dir_r) begin
      phase_step_s = phase_r + 2'd1;
      pos_step_s   = pos_r + 16'd1;
    end else begin
      phase_step_s = phase_r - 2'd1;
      pos_step_s   = pos_r - 16'd1;
    end
    // abort wins over an edge that falls due in the same cycle
    if ((state_r == ST_RUN) && !abort && (div_r == PER_ONE)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Command FSM with rate divider, phase, position and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dir_r       <= 1'b0;
      per_r       <= PER_ONE;
      div_r       <= PER_ZERO;
      remaining_r <= 16'd0;
      phase_r     <= 2'd0;
      tach_r      <= 2'b00;
      pos_r       <= 16'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_r       <= cmd_dir;
            remaining_r <= cmd_steps;
            per_r       <= per_s;
            if (cmd_steps == 16'd0) begin
              // empty command completes immediately without touching tach
              done_r <= 1'b1;
            end else begin
              div_r   <= per_s;
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (fire_s) begin
            phase_r     <= phase_step_s;
            tach_r      <= bin2gray(phase_step_s);
            pos_r       <= pos_step_s;
            remaining_r <= remaining_r - 16'd1;
            div_r       <= per_r;
            if (remaining_r == 16'd1) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            div_r <= div_r - PER_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef QENC_INDEX_EN
  localparam int                 ANGLE_W    = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [ANGLE_W-1:0] ANGLE_MAX  = ANGLE_W'(CPR - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_ZERO = {ANGLE_W{1'b0}};
  localparam logic [ANGLE_W-1:0] ANGLE_ONE  = ANGLE_W'(1);

  logic [ANGLE_W-1:0] angle_r;
  logic [ANGLE_W-1:0] angle_step_s;
  logic               index_r;

  // Next angle with wrap at both ends of 0..CPR-1.
  always_comb begin
    angle_step_s = angle_r;
    if (dir_r) begin
      if (angle_r == ANGLE_MAX) begin
        angle_step_s = ANGLE_ZERO;
      end else begin
        angle_step_s = angle_r + ANGLE_ONE;
      end
    end else begin
      if (angle_r == ANGLE_ZERO) begin
        angle_step_s = ANGLE_MAX;
      end else begin
        angle_step_s = angle_r - ANGLE_ONE;
      end
    end
  end

  // Angle and index move on the same edge as tach so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_r <= ANGLE_ZERO;
      index_r <= 1'b1;
    end else if (fire_s) begin
      angle_r <= angle_step_s;
      index_r <= (angle_step_s == ANGLE_ZERO);
    end
  end

  assign index = index_r;
`else
  logic [31:0] cpr_unused_s;
  assign cpr_unused_s = 32'(CPR);
  assign index        = 1'b0;
`endif

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_RUN);
  assign done      = done_r;
  assign counth    = pos_r[15:8];
  assign countl    = pos_r[7:0];
  // invphase only swaps the pins; internal phase and position are unaffected
  assign tach      = invphase ? {tach_r[0], tach_r[1]} : tach_r;

endmodule
